// File: rtl/pad_bank_pkg.sv
// Shared types and elaboration-time parameter checks for the pad bank.
package pad_bank_pkg;

    // Bank-wide pad pull selection.
    typedef enum logic [1:0] {
        PULL_NONE = 2'd0,
        PULL_UP   = 2'd1,
        PULL_DOWN = 2'd2
    } pull_e;

    localparam int MIN_N_PADS      = 1;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_FILT_CYCLES = 1;

    function automatic bit n_pads_ok(input int n);
        return n >= MIN_N_PADS;
    endfunction

    function automatic bit sync_stages_ok(input int n);
        return n >= MIN_SYNC_STAGES;
    endfunction

    function automatic bit filt_cycles_ok(input int n);
        return n >= MIN_FILT_CYCLES;
    endfunction

    function automatic bit turn_cycles_ok(input int n);
        return n >= 0;
    endfunction

    // Filter counter only has to reach FILT_CYCLES-1; never narrower than 1 bit.
    function automatic int cnt_width(input int filt_cycles);
        return (filt_cycles > 2) ? $clog2(filt_cycles) : 1;
    endfunction

    // Guard counter has to hold TURN_CYCLES itself; never narrower than 1 bit.
    function automatic int guard_width(input int turn_cycles);
        return (turn_cycles > 1) ? $clog2(turn_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/pad_bank_channel.sv
// One bidirectional pad: registered drive, input synchroniser, optional
// glitch filter, direction-turnaround guard and edge pulses.
module pad_bank_channel
    import pad_bank_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter int    FILT_CYCLES = 4,
    parameter int    TURN_CYCLES = 2,
    parameter pull_e PULL        = PULL_NONE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic out_i,
    input  logic oe_i,
    input  logic filt_en_i,
    output logic in_o,
    output logic rise_o,
    output logic fall_o,
    inout  wire  pad_io
);

    localparam int CW = cnt_width(FILT_CYCLES);
    localparam int GW = guard_width(TURN_CYCLES);

    localparam logic [CW-1:0] CNT_LAST   = CW'(FILT_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(TURN_CYCLES);
    localparam bit            FILT_AVAIL = (FILT_CYCLES > 1);

    logic                   out_q;
    logic                   oe_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   pad_in;
    logic                   filt_en_q;
    logic                   in_q;
    logic                   in_d;
    logic [CW-1:0]          cnt;
    logic [GW-1:0]          guard;

    logic                   in_n;
    logic [CW-1:0]          cnt_n;
    logic [GW-1:0]          guard_n;
    logic                   filt_on;

    // Tri-state driver; synthesis maps this onto the pad IOBUF (T = ~oe_q).
    assign pad_io = oe_q ? out_q : 1'bz;
    assign pad_in = pad_io;

    if (PULL == PULL_UP) begin : g_pullup
        pullup pu_i (pad_io);
    end else if (PULL == PULL_DOWN) begin : g_pulldown
        pulldown pd_i (pad_io);
    end

    // Register the drive value and enable so the pad changes one cycle after sampling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= 1'b0;
            oe_q  <= 1'b0;
        end else begin
            out_q <= out_i;
            oe_q  <= oe_i;
        end
    end

    // Synchroniser chain; the last stage is the first trusted sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Previous filter enable, tracked through reset so that reset release is not seen as a toggle.
    always_ff @(posedge clk_i) begin
        filt_en_q <= filt_en_i;
    end

    assign filt_on = filt_en_i && FILT_AVAIL;

    // Next accepted level, filter count and guard count.
    always_comb begin
        in_n    = in_q;
        cnt_n   = cnt;
        guard_n = guard;
        if (guard != '0) begin
            // Input frozen while our own driver's tail drains from the synchroniser.
            cnt_n   = '0;
            guard_n = guard - 1'b1;
        end else if (filt_en_i != filt_en_q) begin
            // Mode change restarts the stability count but keeps the level.
            cnt_n = '0;
        end else if (!filt_on) begin
            in_n  = s;
            cnt_n = '0;
        end else if (s == in_q) begin
            cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
            in_n  = s;
            cnt_n = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end
        // Driver turning off starts the guard; turning back on cancels it.
        if (oe_q && !oe_i) begin
            guard_n = GUARD_LOAD;
        end else if (!oe_q && oe_i) begin
            guard_n = '0;
        end
    end

    // Accepted level, its delayed copy for edge detection, and the counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_q  <= 1'b0;
            in_d  <= 1'b0;
            cnt   <= '0;
            guard <= '0;
        end else begin
            in_q  <= in_n;
            in_d  <= in_q;
            cnt   <= cnt_n;
            guard <= guard_n;
        end
    end

    assign in_o   = in_q;
    assign rise_o = in_q & ~in_d;
    assign fall_o = ~in_q & in_d;

endmodule

// File: rtl/pad_bank_xilinx.sv
// Bank of N independent bidirectional FPGA pads for the Genesys2 build.
module pad_bank_xilinx
    import pad_bank_pkg::*;
#(
    parameter int    N_PADS      = 8,
    parameter int    SYNC_STAGES = 2,
    parameter int    FILT_CYCLES = 4,
    parameter int    TURN_CYCLES = 2,
    parameter pull_e PULL        = PULL_NONE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_PADS-1:0] out_i,
    input  logic [N_PADS-1:0] oe_i,
    input  logic [N_PADS-1:0] filt_en_i,
    output logic [N_PADS-1:0] in_o,
    output logic [N_PADS-1:0] rise_o,
    output logic [N_PADS-1:0] fall_o,
    inout  wire  [N_PADS-1:0] pad_io
);

    if (!n_pads_ok(N_PADS)) begin : g_bad_n_pads
        $error("pad_bank_xilinx: N_PADS must be at least 1");
    end
    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
        $error("pad_bank_xilinx: SYNC_STAGES must be at least 2");
    end
    if (!filt_cycles_ok(FILT_CYCLES)) begin : g_bad_filt
        $error("pad_bank_xilinx: FILT_CYCLES must be at least 1");
    end
    if (!turn_cycles_ok(TURN_CYCLES)) begin : g_bad_turn
        $error("pad_bank_xilinx: TURN_CYCLES must not be negative");
    end

    for (genvar g = 0; g < N_PADS; g++) begin : g_pad
        pad_bank_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .TURN_CYCLES (TURN_CYCLES),
            .PULL        (PULL)
        ) u_channel (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .out_i     (out_i[g]),
            .oe_i      (oe_i[g]),
            .filt_en_i (filt_en_i[g]),
            .in_o      (in_o[g]),
            .rise_o    (rise_o[g]),
            .fall_o    (fall_o[g]),
            .pad_io    (pad_io[g])
        );
    end

endmodule

// File: tb/tb_pad_bank_xilinx.sv
// Directed bench for pad_bank_xilinx with a per-cycle behavioural model.
module tb_pad_bank_xilinx;
    import pad_bank_pkg::*;

    localparam int N = 8;
    localparam int S = 2;
    localparam int F = 4;
    localparam int T = 2;

    logic         clk       = 1'b0;
    logic         rst_i     = 1'b1;
    logic [N-1:0] out_i     = 8'b0101_0000;
    logic [N-1:0] oe_i      = '0;
    logic [N-1:0] filt_en_i = 8'b0010_0000;
    logic [N-1:0] in_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    wire  [N-1:0] pad_io;

    // External drivers standing in for the board side of each pad.
    logic [N-1:0] ext_oe  = 8'b0010_1000;
    logic [N-1:0] ext_val = '0;

    int n_total = 0;
    int n_bad   = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_ext
        assign pad_io[g] = ext_oe[g] ? ext_val[g] : 1'bz;
    end

    pad_bank_xilinx #(
        .N_PADS      (N),
        .SYNC_STAGES (S),
        .FILT_CYCLES (F),
        .TURN_CYCLES (T),
        .PULL        (PULL_DOWN)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .out_i     (out_i),
        .oe_i      (oe_i),
        .filt_en_i (filt_en_i),
        .in_o      (in_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .pad_io    (pad_io)
    );

    // Behavioural model: per pad, the driven state, a history of pad samples,
    // the accepted level, a run length of disagreeing samples and a freeze count.
    logic         m_out_q [N];
    logic         m_oe_q  [N];
    logic [S-1:0] m_hist  [N];
    logic         m_in    [N];
    logic         m_ind   [N];
    logic         m_fen   [N];
    int           m_run   [N];
    int           m_freeze[N];

    logic [3*N-1:0] exp_q[$];

    // Level on the pad wire: our driver, else the board, else the pull-down.
    function automatic logic model_pad(input int p);
        if (m_oe_q[p]) return m_out_q[p];
        if (ext_oe[p]) return ext_val[p];
        return 1'b0;
    endfunction

    task automatic model_step();
        logic         smp;
        logic         nxt;
        logic         lvl;
        logic [N-1:0] v_in;
        logic [N-1:0] v_rise;
        logic [N-1:0] v_fall;
        for (int p = 0; p < N; p++) begin
            lvl = model_pad(p);
            if (rst_i) begin
                m_out_q[p]  = 1'b0;
                m_oe_q[p]   = 1'b0;
                m_hist[p]   = '0;
                m_in[p]     = 1'b0;
                m_ind[p]    = 1'b0;
                m_run[p]    = 0;
                m_freeze[p] = 0;
            end else begin
                smp = m_hist[p][S-1];
                nxt = m_in[p];
                if (m_freeze[p] > 0) begin
                    m_freeze[p] = m_freeze[p] - 1;
                    m_run[p]    = 0;
                end else if (filt_en_i[p] != m_fen[p]) begin
                    m_run[p] = 0;
                end else if (!filt_en_i[p]) begin
                    nxt      = smp;
                    m_run[p] = 0;
                end else if (smp == m_in[p]) begin
                    m_run[p] = 0;
                end else begin
                    m_run[p] = m_run[p] + 1;
                    if (m_run[p] >= F) begin
                        nxt      = smp;
                        m_run[p] = 0;
                    end
                end
                if (m_oe_q[p] && !oe_i[p]) m_freeze[p] = T;
                else if (!m_oe_q[p] && oe_i[p]) m_freeze[p] = 0;
                m_ind[p]   = m_in[p];
                m_in[p]    = nxt;
                m_hist[p]  = {m_hist[p][S-2:0], lvl};
                m_out_q[p] = out_i[p];
                m_oe_q[p]  = oe_i[p];
            end
            m_fen[p] = filt_en_i[p];
        end
        for (int p = 0; p < N; p++) begin
            v_in[p]   = m_in[p];
            v_rise[p] = m_in[p] & ~m_ind[p];
            v_fall[p] = ~m_in[p] & m_ind[p];
        end
        exp_q.push_back({v_in, v_rise, v_fall});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Scoreboard checks
    task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    logic [3*N-1:0] exp_word;
    logic [N-1:0]   exp_pad;

    // Compare process: every cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL scoreboard: got empty queue expected entry at %0t", $time);
            end else begin
                exp_word = exp_q.pop_front();
                check_vec("model in_o", in_o, exp_word[3*N-1:2*N]);
                check_vec("model rise_o", rise_o, exp_word[2*N-1:N]);
                check_vec("model fall_o", fall_o, exp_word[N-1:0]);
                for (int p = 0; p < N; p++) exp_pad[p] = model_pad(p);
                check_vec("model pad_io", pad_io, exp_pad);
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick(3);
        check_vec("reset in_o", in_o, 8'h00);
        check_vec("reset rise_o", rise_o, 8'h00);
        check_vec("reset fall_o", fall_o, 8'h00);
        check_bit("reset pad0 tristated", pad_io[0], 1'b0);
        rst_i = 1'b0;
        tick(4);

        // Drive pad 0 high: pad follows after one edge, in_o three edges later
        oe_i[0]  = 1'b1;
        out_i[0] = 1'b1;
        tick(1);
        check_bit("drive pad0", pad_io[0], 1'b1);
        check_bit("pulled pad1", pad_io[1], 1'b0);
        tick(2);
        check_bit("readback pad0 early", in_o[0], 1'b0);
        tick(1);
        check_bit("readback pad0 in", in_o[0], 1'b1);
        check_bit("readback pad0 rise", rise_o[0], 1'b1);
        tick(1);
        check_bit("readback pad0 rise single", rise_o[0], 1'b0);

        // Unfiltered external toggle on pad 3
        ext_val[3] = 1'b1;
        tick(2);
        check_bit("pad3 rise early", in_o[3], 1'b0);
        tick(1);
        check_bit("pad3 in high", in_o[3], 1'b1);
        check_bit("pad3 rise", rise_o[3], 1'b1);
        tick(1);
        check_bit("pad3 rise single", rise_o[3], 1'b0);
        ext_val[3] = 1'b0;
        tick(3);
        check_bit("pad3 in low", in_o[3], 1'b0);
        check_bit("pad3 fall", fall_o[3], 1'b1);
        tick(1);
        check_bit("pad3 fall single", fall_o[3], 1'b0);

        // Filtered pad 5: a 3-cycle glitch is rejected
        ext_val[5] = 1'b1;
        tick(3);
        ext_val[5] = 1'b0;
        tick(8);
        check_bit("pad5 glitch rejected", in_o[5], 1'b0);

        // Filtered pad 5: a 4-cycle pulse is accepted 6 edges after it starts
        ext_val[5] = 1'b1;
        tick(4);
        ext_val[5] = 1'b0;
        tick(1);
        check_bit("pad5 filt early", in_o[5], 1'b0);
        tick(1);
        check_bit("pad5 filt in", in_o[5], 1'b1);
        check_bit("pad5 filt rise", rise_o[5], 1'b1);
        tick(6);
        check_bit("pad5 filt back low", in_o[5], 1'b0);

        // Filter enable toggled with the count at 2 restarts the count
        ext_val[5] = 1'b1;
        tick(4);
        filt_en_i[5] = 1'b0;
        tick(1);
        filt_en_i[5] = 1'b1;
        tick(4);
        check_bit("pad5 toggle restart", in_o[5], 1'b0);
        tick(1);
        check_bit("pad5 toggle in", in_o[5], 1'b1);
        check_bit("pad5 toggle rise", rise_o[5], 1'b1);
        ext_val[5] = 1'b0;
        tick(8);
        check_bit("pad5 toggle settle", in_o[5], 1'b0);

        // Pad 4: re-enable during the guard cancels it; board drives the gap
        oe_i[4] = 1'b1;
        tick(1);
        oe_i[4] = 1'b0;
        tick(1);
        oe_i[4]    = 1'b1;
        ext_oe[4]  = 1'b1;
        ext_val[4] = 1'b1;
        tick(1);
        ext_oe[4] = 1'b0;
        check_bit("pad4 cleared guard early", in_o[4], 1'b0);
        tick(1);
        check_bit("pad4 cleared guard in", in_o[4], 1'b1);
        check_bit("pad4 cleared guard rise", rise_o[4], 1'b1);

        // Pad 6: a one-cycle drive pulse is hidden by the guard
        oe_i[6] = 1'b1;
        tick(1);
        oe_i[6] = 1'b0;
        tick(3);
        check_bit("pad6 tail masked", in_o[6], 1'b0);
        tick(3);
        check_bit("pad6 tail masked late", in_o[6], 1'b0);

        // Pad 0: brief release then re-enable gives a one-cycle dip
        oe_i[0] = 1'b0;
        tick(1);
        oe_i[0] = 1'b1;
        tick(2);
        check_bit("pad0 dip hold", in_o[0], 1'b1);
        tick(1);
        check_bit("pad0 dip low", in_o[0], 1'b0);
        check_bit("pad0 dip fall", fall_o[0], 1'b1);
        tick(1);
        check_bit("pad0 dip back", in_o[0], 1'b1);
        check_bit("pad0 dip rise", rise_o[0], 1'b1);
        tick(3);

        // Pad 0: full release with pull-down; holds, then one fall
        oe_i[0] = 1'b0;
        tick(3);
        check_bit("pad0 release hold", in_o[0], 1'b1);
        tick(1);
        check_bit("pad0 release low", in_o[0], 1'b0);
        check_bit("pad0 release fall", fall_o[0], 1'b1);
        tick(1);
        check_bit("pad0 release fall single", fall_o[0], 1'b0);
        tick(3);

        // Reset mid-filter with pad 5 held high
        ext_val[5] = 1'b1;
        tick(3);
        rst_i = 1'b1;
        tick(1);
        check_vec("midreset in_o", in_o, 8'h00);
        check_vec("midreset rise_o", rise_o, 8'h00);
        check_vec("midreset fall_o", fall_o, 8'h00);
        tick(1);
        rst_i = 1'b0;
        tick(5);
        check_bit("postreset pad5 early", in_o[5], 1'b0);
        tick(1);
        check_bit("postreset pad5 in", in_o[5], 1'b1);
        check_bit("postreset pad5 rise", rise_o[5], 1'b1);
        tick(1);
        check_bit("postreset pad5 rise single", rise_o[5], 1'b0);
        tick(4);

        // Final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
